// File: rtl/tx_link_pkg.sv
// Shared types and constants for the SerDes TX link trainer and the PRBS7 generator
// that the RX-side pattern checker also uses.
package tx_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_TRAIN    = 2'd2,
    ST_DATA     = 2'd3
  } tx_link_state_t;

  // PRBS7, x^7 + x^6 + 1: feedback is the XOR of bits 6 and 5, shifted in at bit 0.
  localparam logic [6:0] PRBS7_SEED   = 7'h7F;
  localparam int         PRBS7_TAP_HI = 6;
  localparam int         PRBS7_TAP_LO = 5;
  localparam int         PRBS7_PERIOD = 127;

  localparam real TX_HIGH = 1.0;
  localparam real TX_LOW  = 0.0;

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 (x^7+x^6+1) generator; bit_out is the register MSB.
// seed_load has priority over advance.
module prbs7_gen
  import tx_link_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic seed_load,
  input  logic advance,
  output logic bit_out
);

  logic [6:0] prbs_q, prbs_d;

  always_comb begin
    prbs_d = prbs_q;
    if (seed_load) begin
      prbs_d = PRBS7_SEED;
    end else if (advance) begin
      prbs_d = {prbs_q[5:0], prbs_q[PRBS7_TAP_HI] ^ prbs_q[PRBS7_TAP_LO]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prbs_q <= PRBS7_SEED;
    else     prbs_q <= prbs_d;
  end

  assign bit_out = prbs_q[PRBS7_TAP_HI];

endmodule

// File: rtl/tx_link_trainer.sv
// TX link-training sequencer/serializer: alternating preamble, PRBS7 training, then payload MSB first.
// Defining TX_LINK_TRAINER_PRECODE_EN enables 1/(1+D) precoding of payload bits.
module tx_link_trainer
  import tx_link_pkg::*;
#(
  parameter int                DATA_W       = 10,
  parameter int                PRE_LEN      = 64,
  parameter int                TRAIN_REPEAT = 4,
  parameter logic [DATA_W-1:0] FILL_WORD    = 10'h17C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              serial_out,
  output real               tx_out,
  output logic              busy,
  output logic              train_done,
  output logic [15:0]       underflow_cnt
);

  localparam logic [15:0] PRE_LAST   = 16'(PRE_LEN - 1);
  localparam logic [15:0] TRAIN_LAST = 16'(PRBS7_PERIOD * TRAIN_REPEAT - 1);
  localparam logic [15:0] WORD_LAST  = 16'(DATA_W - 1);

  tx_link_state_t    state_q, state_d;
  logic [15:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [15:0]       underflow_q, underflow_d;
  logic              serial_q, serial_d;
  logic              stop_pend_q, stop_pend_d;
  logic              busy_q, train_done_q;
  logic              prbs_bit, data_bit, prev_p;
  logic              stop_req, train_last, word_last;
  logic [DATA_W-1:0] load_word;

  // The generator sits one step ahead of the line: held at the seed until TRAIN
  // is entered, then advanced on every edge whose next bit is a TRAIN bit.
  prbs7_gen u_prbs (
    .clk       (clk),
    .rst       (rst),
    .seed_load (state_d != ST_TRAIN),
    .advance   (state_d == ST_TRAIN),
    .bit_out   (prbs_bit)
  );

  assign stop_req   = stop | stop_pend_q;
  assign train_last = (state_q == ST_TRAIN) && (bit_cnt_q == TRAIN_LAST);
  assign word_last  = (state_q == ST_DATA)  && (bit_cnt_q == WORD_LAST);
  assign data_ready = (train_last || word_last) && !stop_req;
  assign load_word  = data_valid ? data_in : FILL_WORD;

`ifdef TX_LINK_TRAINER_PRECODE_EN
  // The previous precoded bit is simply the bit on the line while in DATA.
  assign prev_p = (state_q == ST_DATA) ? serial_q : 1'b0;
`else
  assign prev_p = 1'b0;
`endif

  // serial_d is the bit that will be on the line after this edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 16'd1;
    shreg_d     = shreg_q;
    serial_d    = 1'b0;
    stop_pend_d = 1'b0;
    data_bit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (start && !stop) begin
          state_d  = ST_PREAMBLE;
          serial_d = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        if (stop) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end else if (bit_cnt_q == PRE_LAST) begin
          state_d   = ST_TRAIN;
          bit_cnt_d = '0;
          serial_d  = prbs_bit;
        end else begin
          serial_d = bit_cnt_q[0];
        end
      end
      ST_TRAIN: begin
        if (stop) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end else if (train_last) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          shreg_d   = load_word;
          data_bit  = load_word[DATA_W-1];
        end else begin
          serial_d = prbs_bit;
        end
      end
      ST_DATA: begin
        stop_pend_d = stop_req;
        if (word_last) begin
          bit_cnt_d = '0;
          if (data_ready) begin
            shreg_d  = load_word;
            data_bit = load_word[DATA_W-1];
          end else begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
          end
        end else begin
          shreg_d  = shreg_q << 1;
          data_bit = shreg_q[DATA_W-2];
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
    endcase
    if (state_d == ST_DATA) serial_d = data_bit ^ prev_p;
  end

  always_comb begin
    underflow_d = underflow_q;
    if (data_ready && !data_valid && underflow_q != 16'hFFFF) underflow_d = underflow_q + 16'd1;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      serial_q     <= 1'b0;
      stop_pend_q  <= 1'b0;
      underflow_q  <= '0;
      busy_q       <= 1'b0;
      train_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      serial_q     <= serial_d;
      stop_pend_q  <= stop_pend_d;
      underflow_q  <= underflow_d;
      busy_q       <= (state_d != ST_IDLE);
      train_done_q <= (state_d == ST_DATA);
    end
  end

  assign serial_out    = serial_q;
  assign tx_out        = serial_q ? TX_HIGH : TX_LOW;
  assign busy          = busy_q;
  assign train_done    = train_done_q;
  assign underflow_cnt = underflow_q;

endmodule
